// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module  : cpu_types_pkg
// Brief   : Shared CPU datapath types plus hazard-tracking shadow records.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;
    typedef logic [5:0]  opcode_t;
    typedef logic [5:0]  funct_t;

    // Per-stage shadow of what the hazard unit needs to see
    typedef struct packed {
        regbits_t dest;
        logic     regwrite;
        logic     memread;
    } stage_t;

    typedef struct packed {
        regbits_t    rs;
        regbits_t    rt;
        funct_t      funct;
        stage_t      ctl;
        logic [1:0]  alusrc;
    } idex_t;

    // sll $0, $0, 0
    localparam word_t BUBBLE_INSTR = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/hazard_stage_reg.sv
// ============================================================================
// Module  : hazard_stage_reg
// Brief   : Generic pipeline latch; reset/flush load a bubble, stall holds.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stage_reg #(
    parameter int             W      = 8,
    parameter logic [W-1:0]   BUBBLE = '0
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         stall_i,
    input  logic         flush_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge CLK) begin
        if (!nRST || flush_i) begin
            q_o <= BUBBLE;
        end else if (!stall_i) begin
            q_o <= d_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_track.sv
// ============================================================================
// Module  : hazard_track
// Brief   : IF/ID latch and EX/MEM/WB shadow registers feeding the hazard unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_track
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [31:0]      instr_in,
    input  logic [4:0]       dec_dest,
    input  logic             dec_regwrite,
    input  logic             dec_memread,
    input  logic [1:0]       dec_alusrc,
    input  logic             fetch_stall,
    input  logic             fetch_flush,
    input  logic             decode_stall,
    input  logic             decode_flush,
    input  logic             execute_stall,
    input  logic             execute_flush,
    input  logic             memory_stall,
    input  logic             memory_flush,
    input  logic             PCStall,
    output logic [31:0]      instr_id,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [5:0]       opcode,
    output logic [4:0]       rs_f,
    output logic [4:0]       rt_f,
    output logic [5:0]       rfunct,
    output logic [1:0]       ALUSrc,
    output logic [4:0]       execDest,
    output logic [4:0]       memDest,
    output logic [4:0]       wbDest,
    output logic             writeReg_exec,
    output logic             writeReg_mem,
    output logic             writeReg_wb,
    output logic             MemRead_Ex,
    output logic             MemRead_Mem,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MEMWB_W = $bits(regbits_t) + 1;

    word_t               ifid_q;
    idex_t               idex_d, idex_q;
    stage_t              exmem_q;
    logic [MEMWB_W-1:0]  memwb_d, memwb_q;
    logic [CNT_W-1:0]    stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0]    flush_cnt_d, flush_cnt_q;
    logic                any_flush;

    hazard_stage_reg #(.W($bits(word_t)), .BUBBLE(BUBBLE_INSTR)) u_ifid (
        .CLK(CLK), .nRST(nRST), .stall_i(fetch_stall), .flush_i(fetch_flush),
        .d_i(instr_in), .q_o(ifid_q)
    );

    // $zero is never a forwarding source, so its write-enable is dropped here
    always_comb begin
        idex_d              = '0;
        idex_d.rs           = ifid_q[25:21];
        idex_d.rt           = ifid_q[20:16];
        idex_d.funct        = ifid_q[5:0];
        idex_d.ctl.dest     = dec_dest;
        idex_d.ctl.regwrite = dec_regwrite && (dec_dest != 5'd0);
        idex_d.ctl.memread  = dec_memread;
        idex_d.alusrc       = dec_alusrc;
    end

    hazard_stage_reg #(.W($bits(idex_t))) u_idex (
        .CLK(CLK), .nRST(nRST), .stall_i(decode_stall), .flush_i(decode_flush),
        .d_i(idex_d), .q_o(idex_q)
    );

    hazard_stage_reg #(.W($bits(stage_t))) u_exmem (
        .CLK(CLK), .nRST(nRST), .stall_i(execute_stall), .flush_i(execute_flush),
        .d_i(idex_q.ctl), .q_o(exmem_q)
    );

    assign memwb_d = {exmem_q.dest, exmem_q.regwrite};

    hazard_stage_reg #(.W(MEMWB_W)) u_memwb (
        .CLK(CLK), .nRST(nRST), .stall_i(memory_stall), .flush_i(memory_flush),
        .d_i(memwb_d), .q_o(memwb_q)
    );

    assign any_flush = fetch_flush | decode_flush | execute_flush | memory_flush;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (PCStall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (any_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign instr_id      = ifid_q;
    assign rs            = ifid_q[25:21];
    assign rt            = ifid_q[20:16];
    assign opcode        = ifid_q[31:26];
    assign rs_f          = idex_q.rs;
    assign rt_f          = idex_q.rt;
    assign rfunct        = idex_q.funct;
    assign ALUSrc        = idex_q.alusrc;
    assign execDest      = idex_q.ctl.dest;
    assign writeReg_exec = idex_q.ctl.regwrite;
    assign MemRead_Ex    = idex_q.ctl.memread;
    assign memDest       = exmem_q.dest;
    assign writeReg_mem  = exmem_q.regwrite;
    assign MemRead_Mem   = exmem_q.memread;
    assign wbDest        = memwb_q[MEMWB_W-1:1];
    assign writeReg_wb   = memwb_q[0];
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_track.sv
// ============================================================================
// Module  : tb_hazard_track
// Brief   : Self-checking bench for hazard_track against a pipeline model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_track;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int VEC_W = 32 + 5 + 5 + 6 + 2 + 15 + 3 + 2 + 2 * CNT_W;

    logic CLK = 1'b0;
    logic nRST;
    logic [31:0] instr_in;
    logic [4:0]  dec_dest;
    logic        dec_regwrite, dec_memread;
    logic [1:0]  dec_alusrc;
    logic fetch_stall, fetch_flush, decode_stall, decode_flush;
    logic execute_stall, execute_flush, memory_stall, memory_flush, PCStall;
    logic [31:0] instr_id;
    logic [4:0]  rs, rt, rs_f, rt_f, execDest, memDest, wbDest;
    logic [5:0]  opcode, rfunct;
    logic [1:0]  ALUSrc;
    logic writeReg_exec, writeReg_mem, writeReg_wb, MemRead_Ex, MemRead_Mem;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_track #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .instr_in(instr_in), .dec_dest(dec_dest),
        .dec_regwrite(dec_regwrite), .dec_memread(dec_memread), .dec_alusrc(dec_alusrc),
        .fetch_stall(fetch_stall), .fetch_flush(fetch_flush),
        .decode_stall(decode_stall), .decode_flush(decode_flush),
        .execute_stall(execute_stall), .execute_flush(execute_flush),
        .memory_stall(memory_stall), .memory_flush(memory_flush), .PCStall(PCStall),
        .instr_id(instr_id), .rs(rs), .rt(rt), .opcode(opcode), .rs_f(rs_f), .rt_f(rt_f),
        .rfunct(rfunct), .ALUSrc(ALUSrc), .execDest(execDest), .memDest(memDest),
        .wbDest(wbDest), .writeReg_exec(writeReg_exec), .writeReg_mem(writeReg_mem),
        .writeReg_wb(writeReg_wb), .MemRead_Ex(MemRead_Ex), .MemRead_Mem(MemRead_Mem),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    // Reference model: each stage carries a whole instruction record
    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic [1:0]  alu;
    } rec_t;

    logic [31:0] m_if;
    rec_t        m_ex, m_mem, m_wb;
    int          m_sc, m_fc;

    function automatic logic [CNT_W-1:0] sat(input int c);
        return (c > CMAX) ? CMAX[CNT_W-1:0] : c[CNT_W-1:0];
    endfunction

    function automatic logic [VEC_W-1:0] model_vec();
        return {m_if, m_ex.instr[25:21], m_ex.instr[20:16], m_ex.instr[5:0], m_ex.alu,
                m_ex.dest, m_mem.dest, m_wb.dest, m_ex.rw, m_mem.rw, m_wb.rw,
                m_ex.mr, m_mem.mr, sat(m_sc), sat(m_fc)};
    endfunction

    wire [VEC_W-1:0] dut_vec = {instr_id, rs_f, rt_f, rfunct, ALUSrc, execDest, memDest,
                                wbDest, writeReg_exec, writeReg_mem, writeReg_wb,
                                MemRead_Ex, MemRead_Mem, stall_cnt, flush_cnt};

    task automatic tick();
        rec_t n_ex, n_mem, n_wb;
        logic [31:0] n_if;
        @(posedge CLK);
        if (!nRST) begin
            m_if = '0; m_ex = '0; m_mem = '0; m_wb = '0; m_sc = 0; m_fc = 0;
        end else begin
            n_wb  = memory_flush  ? '0 : (memory_stall  ? m_wb  : m_mem);
            n_mem = execute_flush ? '0 : (execute_stall ? m_mem : m_ex);
            if (decode_flush)      n_ex = '0;
            else if (decode_stall) n_ex = m_ex;
            else n_ex = '{instr: m_if, dest: dec_dest, rw: dec_regwrite && (dec_dest != 0),
                          mr: dec_memread, alu: dec_alusrc};
            n_if  = fetch_flush ? '0 : (fetch_stall ? m_if : instr_in);
            n_wb.mr = 1'b0;
            m_if = n_if; m_ex = n_ex; m_mem = n_mem; m_wb = n_wb;
            if (PCStall) m_sc++;
            if (fetch_flush || decode_flush || execute_flush || memory_flush) m_fc++;
        end
        #1;
    endtask

    task automatic clear_inputs();
        nRST = 1'b1; instr_in = '0; dec_dest = '0; dec_regwrite = 0; dec_memread = 0;
        dec_alusrc = '0; fetch_stall = 0; fetch_flush = 0; decode_stall = 0;
        decode_flush = 0; execute_stall = 0; execute_flush = 0; memory_stall = 0;
        memory_flush = 0; PCStall = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 1'b0; instr_in = 32'hFFFF_FFFF; dec_dest = 5'd31; dec_regwrite = 1;
        dec_memread = 1; dec_alusrc = 2'b11; PCStall = 1; fetch_stall = 1; decode_flush = 1;
        execute_stall = 1; memory_flush = 1;
        tick(); tick();
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", dut_vec);
        end
        checks++;
        if ({rs, rt, opcode} !== 16'h0) begin
            errors++; $display("FAIL reset_fields got %h want 0", {rs, rt, opcode});
        end
        clear_inputs();
    endtask

    task automatic test_flow_through();
        do_reset();
        instr_in = 32'h012A_4020; dec_dest = 5'd8; dec_regwrite = 1;
        tick();
        instr_in = '0;
        checks++;
        if ({rs, rt, opcode} !== {5'd9, 5'd10, 6'd0}) begin
            errors++; $display("FAIL flow_ifid got rs=%0d rt=%0d op=%0d want 9 10 0", rs, rt, opcode);
        end
        tick();
        dec_dest = '0; dec_regwrite = 0;
        checks++;
        if ({execDest, writeReg_exec, rs_f, rt_f, rfunct} !== {5'd8, 1'b1, 5'd9, 5'd10, 6'h20}) begin
            errors++; $display("FAIL flow_ex got dest=%0d wr=%b rs=%0d rt=%0d fn=%h want 8 1 9 10 20",
                               execDest, writeReg_exec, rs_f, rt_f, rfunct);
        end
        tick();
        checks++;
        if ({memDest, writeReg_mem} !== {5'd8, 1'b1}) begin
            errors++; $display("FAIL flow_mem got dest=%0d wr=%b want 8 1", memDest, writeReg_mem);
        end
        tick();
        checks++;
        if ({wbDest, writeReg_wb} !== {5'd8, 1'b1}) begin
            errors++; $display("FAIL flow_wb got dest=%0d wr=%b want 8 1", wbDest, writeReg_wb);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        instr_in = 32'h8C22_0000;
        tick();
        instr_in = 32'h0042_1820; dec_dest = 5'd2; dec_regwrite = 1; dec_memread = 1; dec_alusrc = 2'd1;
        tick();
        checks++;
        if ({MemRead_Ex, execDest, rs, rt} !== {1'b1, 5'd2, 5'd2, 5'd2}) begin
            errors++; $display("FAIL loaduse_ex got mr=%b dest=%0d rs=%0d rt=%0d want 1 2 2 2",
                               MemRead_Ex, execDest, rs, rt);
        end
        instr_in = 32'h0000_0000; dec_dest = 5'd3; dec_memread = 0; dec_alusrc = 2'd0;
        decode_flush = 1; fetch_stall = 1;
        tick();
        decode_flush = 0; fetch_stall = 0;
        checks++;
        if ({execDest, writeReg_exec, MemRead_Ex, rs, rt, MemRead_Mem, memDest}
            !== {5'd0, 1'b0, 1'b0, 5'd2, 5'd2, 1'b1, 5'd2}) begin
            errors++; $display("FAIL loaduse_bubble got ex=%0d/%b/%b rs=%0d rt=%0d mem=%b/%0d want 0/0/0 2 2 1/2",
                               execDest, writeReg_exec, MemRead_Ex, rs, rt, MemRead_Mem, memDest);
        end
        checks++;
        if (flush_cnt !== 4'd1) begin
            errors++; $display("FAIL loaduse_flush_cnt got %0d want 1", flush_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_conflict();
        do_reset();
        instr_in = 32'h1234_5678;
        tick();
        dec_dest = 5'd5; dec_regwrite = 1;
        tick();
        dec_dest = 5'd7;
        tick();
        checks++;
        if (memDest !== 5'd5) begin
            errors++; $display("FAIL conflict_setup got memDest=%0d want 5", memDest);
        end
        execute_stall = 1;
        tick();
        checks++;
        if (memDest !== 5'd5) begin
            errors++; $display("FAIL stall_hold got memDest=%0d want 5", memDest);
        end
        execute_flush = 1;
        tick();
        checks++;
        if ({memDest, writeReg_mem} !== {5'd0, 1'b0}) begin
            errors++; $display("FAIL conflict_flush_wins got memDest=%0d wr=%b want 0 0", memDest, writeReg_mem);
        end
        clear_inputs();
    endtask

    task automatic test_zero_reg();
        do_reset();
        instr_in = 32'h8C20_0000;
        tick();
        dec_dest = 5'd0; dec_regwrite = 1; dec_memread = 1;
        tick();
        checks++;
        if ({writeReg_exec, MemRead_Ex} !== 2'b01) begin
            errors++; $display("FAIL zero_reg got wr=%b mr=%b want 0 1", writeReg_exec, MemRead_Ex);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            nRST          = ($urandom_range(0, 59) != 0);
            instr_in      = $urandom;
            dec_dest      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            dec_regwrite  = 1'($urandom);
            dec_memread   = 1'($urandom);
            dec_alusrc    = 2'($urandom);
            fetch_stall   = ($urandom_range(0, 4) == 0);
            fetch_flush   = ($urandom_range(0, 7) == 0);
            decode_stall  = ($urandom_range(0, 4) == 0);
            decode_flush  = ($urandom_range(0, 7) == 0);
            execute_stall = ($urandom_range(0, 4) == 0);
            execute_flush = ($urandom_range(0, 7) == 0);
            memory_stall  = ($urandom_range(0, 4) == 0);
            memory_flush  = ($urandom_range(0, 7) == 0);
            PCStall       = 1'($urandom);
            tick();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL random_cycle_%0d got %h want %h", i, dut_vec, model_vec());
            end
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        PCStall = 1; fetch_flush = 1; decode_flush = 1;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            tick();
            if (i == CMAX - 2) begin
                checks++;
                if (stall_cnt !== 4'd14) begin
                    errors++; $display("FAIL sat_midway got %0d want 14", stall_cnt);
                end
            end
        end
        checks++;
        if ({stall_cnt, flush_cnt} !== 8'hFF) begin
            errors++; $display("FAIL sat_final got stall=%0d flush=%0d want 15 15", stall_cnt, flush_cnt);
        end
        nRST = 0;
        tick();
        checks++;
        if ({stall_cnt, flush_cnt} !== 8'h00) begin
            errors++; $display("FAIL sat_reset got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        m_if = '0; m_ex = '0; m_mem = '0; m_wb = '0; m_sc = 0; m_fc = 0;
        test_reset();
        test_flow_through();
        test_load_use();
        test_conflict();
        test_zero_reg();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
